// File: rtl/seq_pkg.sv
// seq_pkg: shared types and defaults for the serial
// sequence-detector front end and its benches.
package seq_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    localparam int SEQ_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: WIDTH-bit loadable right-shift register.
// Load wins over shift; bit 0 is exposed as q0.
module seq_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // next value: parallel load, else shift toward bit 0
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = d;
        end else if (shift) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // storage, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q0 = shreg_q[0];

endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: parallel words in over valid/ready,
// one bit per clock out LSB first, one-word hold buffer.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             word_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state_q;
    ser_state_t       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] hold_data_q;
    logic [WIDTH-1:0] hold_data_d;
    logic             hold_full_q;
    logic             hold_full_d;

    logic             acc;
    logic             last;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_d;
    logic             sr_q0;

    assign acc  = in_valid && in_ready;
    assign last = (cnt_q == LAST);

    // next state: idle load, mid-word shift/hold, last-bit reload
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_d        = in_data;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!last) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (acc) begin
                        hold_data_d = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // held word drains first; in_ready is low here
                    sr_load     = 1'b1;
                    sr_d        = hold_data_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (acc) begin
                    sr_load = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // FSM, bit counter and holding buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

    seq_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load),
        .shift (sr_shift),
        .d     (sr_d),
        .q0    (sr_q0)
    );

    // outputs decoded from registers only
    assign ser_valid  = (state_q == S_SHIFT);
    assign ser_bit    = ser_valid && sr_q0;
    assign word_start = ser_valid && (cnt_q == '0);
    assign busy       = ser_valid || hold_full_q;
    assign in_ready   = !hold_full_q && !rst;

endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: bit-queue model of the serializer
// plus directed scenarios with literal expectations.
module tb_seq_serializer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_bit;
    logic         ser_valid;
    logic         word_start;
    logic         busy;

    int n_cmp = 0;
    int n_mis = 0;

    seq_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .word_start (word_start),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: queue of upcoming output bits. Head is the bit on
    // the line now. Room for a new word while <= W bits remain.
    typedef struct packed {
        logic b;
        logic s;
    } mb_t;

    mb_t mq[$];
    bit  macc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            macc = in_valid && (mq.size() <= W);
            if (mq.size() > 0) void'(mq.pop_front());
            if (macc) begin
                for (int k = 0; k < W; k++)
                    mq.push_back('{in_data[k], k == 0});
            end
        end
    end

    always @(negedge clk) begin
        logic ev;
        ev = (mq.size() > 0);
        chk("ser_valid", ser_valid, ev);
        chk("ser_bit", ser_bit, ev ? mq[0].b : 1'b0);
        chk("word_start", word_start, ev ? mq[0].s : 1'b0);
        chk("busy", busy, ev);
        chk("in_ready", in_ready, !rst && (mq.size() <= W));
    end

    // observer of the serial stream
    logic obs[$];
    int   run = 0;
    int   max_run = 0;
    int   n_starts = 0;
    int   n_rdy_low = 0;

    always @(negedge clk) begin
        if (ser_valid) begin
            obs.push_back(ser_bit);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (word_start) n_starts++;
        if (!rst && !in_ready) n_rdy_low++;
    end

    task automatic clear_obs();
        obs.delete();
        max_run = 0;
        n_starts = 0;
        n_rdy_low = 0;
    endtask

    function automatic logic [W-1:0] obs_word(int base);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++)
            if (base + k < obs.size()) r[k] = obs[base + k];
        return r;
    endfunction

    // call at a negedge; returns at the negedge after accept
    task automatic send(input logic [W-1:0] w);
        logic rdy;
        int   n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_valid", ser_valid, 0);
    endtask

    initial begin
        logic [0:15] pat;
        int hits;
        int first_hit;
        int last_hit;
        int r3;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // reset held while in_valid toggles
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = 16'hBEEF;
        end
        #1;
        chk("rst_valid", ser_valid, 0);
        chk("rst_bit", ser_bit, 0);
        chk("rst_start", word_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(negedge clk);

        // single word
        clear_obs();
        send(16'h5773);
        wait_idle();
        pat = 16'b1100_1110_1110_1010;
        chk("single_len", obs.size(), 16);
        for (int k = 0; k < 16; k++)
            chk("single_bit", obs[k], pat[k]);
        chk("single_word", obs_word(0), 16'h5773);
        chk("single_starts", n_starts, 1);
        chk("single_run", max_run, 16);

        // back-to-back, second word lands in hold
        @(negedge clk);
        clear_obs();
        send(16'hFFFF);
        send(16'h0000);
        wait_idle();
        chk("b2b_len", obs.size(), 32);
        chk("b2b_run", max_run, 32);
        chk("b2b_w0", obs_word(0), 16'hFFFF);
        chk("b2b_w1", obs_word(16), 16'h0000);
        chk("b2b_starts", n_starts, 2);
        chk("b2b_rdy_low", n_rdy_low, 15);
        hits = 0;
        first_hit = -1;
        last_hit = -1;
        r3 = 0;
        foreach (obs[k]) begin
            r3 = obs[k] ? r3 + 1 : 0;
            if (r3 >= 3) begin
                hits++;
                if (first_hit < 0) first_hit = k;
                last_hit = k;
            end
        end
        chk("det_hits", hits, 14);
        chk("det_first", first_hit, 2);
        chk("det_last", last_hit, 15);

        // word offered exactly on the last bit, hold empty
        @(negedge clk);
        clear_obs();
        send(16'hC3A5);
        repeat (15) @(negedge clk);
        send(16'h0F1E);
        wait_idle();
        chk("direct_run", max_run, 32);
        chk("direct_w0", obs_word(0), 16'hC3A5);
        chk("direct_w1", obs_word(16), 16'h0F1E);
        chk("direct_rdy_low", n_rdy_low, 0);

        // hold full on the last bit: hold drains first
        @(negedge clk);
        clear_obs();
        send(16'h1357);
        send(16'h9BDF);
        send(16'h2468);
        wait_idle();
        chk("hold_run", max_run, 48);
        chk("hold_w0", obs_word(0), 16'h1357);
        chk("hold_w1", obs_word(16), 16'h9BDF);
        chk("hold_w2", obs_word(32), 16'h2468);
        chk("hold_starts", n_starts, 3);
        chk("hold_rdy_low", n_rdy_low, 30);

        // reset after 7 bits with a second word held
        @(negedge clk);
        clear_obs();
        send(16'hAAAA);
        send(16'h5555);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid", ser_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst_len", obs.size(), 7);
        chk("mrst_bits", obs_word(0), 16'h002A);
        clear_obs();
        send(16'h1234);
        wait_idle();
        chk("fresh_len", obs.size(), 16);
        chk("fresh_word", obs_word(0), 16'h1234);
        chk("fresh_starts", n_starts, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
